// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
// slave = loader side, master = byte source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> instruction memory writes.
// Define IMEM_LOADER_CSUM_EN to expect and verify a trailing 8-bit sum byte.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          load_done,
  output logic          load_err,
  output logic [ADDR_W:0] word_count
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_RUN,
    S_ERR
`ifdef IMEM_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_e;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e S_END = S_CSUM;
`else
  localparam state_e S_END = S_RUN;
`endif

  state_e        state, state_nxt;
  logic          armed;
  logic          acc;
  logic [7:0]    len_hi;
  logic [15:0]   len_full;
  logic [CW-1:0] n_words;
  logic [1:0]    byte_cnt;
  logic [23:0]   shreg;
  logic          last_word;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    csum;
`endif

  assign acc       = bus.in_valid && bus.in_ready;
  assign len_full  = {len_hi, bus.in_data};
  assign last_word = (word_count + CW'(1)) == n_words;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LEN_HI;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_HI: if (acc) state_nxt = S_LEN_LO;
      S_LEN_LO: if (acc) begin
        if (len_full > 16'(MAX_WORDS)) state_nxt = S_ERR;
        else if (len_full == '0)       state_nxt = S_END;
        else                           state_nxt = S_DATA;
      end
      S_DATA: if (acc && byte_cnt == 2'd3 && last_word) state_nxt = S_END;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: if (acc) state_nxt = (bus.in_data == csum) ? S_RUN : S_ERR;
`endif
      default: ;
    endcase
  end

  // armed keeps in_ready low until the first edge after reset release
  always_comb begin
    bus.in_ready = 1'b0;
    cpu_reset    = 1'b1;
    load_done    = 1'b0;
    load_err     = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: bus.in_ready = armed;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: bus.in_ready = armed;
`endif
      S_RUN: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      S_ERR: load_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed        <= 1'b0;
      len_hi       <= '0;
      n_words      <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      word_count   <= '0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum         <= '0;
`endif
    end else begin
      armed     <= 1'b1;
      bus.im_we <= 1'b0;
      if (acc) begin
        case (state)
          S_LEN_HI: len_hi  <= bus.in_data;
          S_LEN_LO: n_words <= CW'(len_full);
          S_DATA: begin
            shreg    <= {shreg[15:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            csum     <= csum + bus.in_data;
`endif
            // word_count doubles as the write index: it is the number of words already stored
            if (byte_cnt == 2'd3) begin
              bus.im_we    <= 1'b1;
              bus.im_addr  <= word_count[ADDR_W-1:0];
              bus.im_wdata <= {shreg, bus.in_data};
              word_count   <= word_count + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model plus
// literal expectations for the directed frames.
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_reset, load_done, load_err;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks the byte position within the frame.
  typedef enum {M_LOAD, M_RUN, M_ERR} mstat_e;
  mstat_e            m_st;
  bit                m_armed;
  int unsigned       m_k, m_n, m_wc;
  logic [7:0]        m_hi, m_sum;
  logic [31:0]       m_word;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  logic [31:0]       wq[$];

  task automatic model_reset();
    m_st = M_LOAD; m_armed = 1'b0;
    m_k = 0; m_n = 0; m_wc = 0;
    m_hi = '0; m_sum = '0; m_word = '0;
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (m_k == 0) m_hi = b;
    else if (m_k == 1) begin
      m_n = {m_hi, b};
      if (m_n > MAX_WORDS) m_st = M_ERR;
      else if (m_n == 0 && !CSUM_EN) m_st = M_RUN;
    end else if (m_k < 2 + 4 * m_n) begin
      m_word = {m_word[23:0], b};
      m_sum  = m_sum + b;
      if ((m_k - 2) % 4 == 3) begin
        exp_addr.push_back(ADDR_W'((m_k - 2) / 4));
        exp_data.push_back(m_word);
        m_wc++;
        if (m_k == 1 + 4 * m_n && !CSUM_EN) m_st = M_RUN;
      end
    end else begin
      m_st = (b == m_sum) ? M_RUN : M_ERR;
    end
    m_k++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (bus.in_valid && m_armed && m_st == M_LOAD) model_accept(bus.in_data);
      m_armed = 1'b1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    bit exp_we;
    exp_we = exp_addr.size() > 0;
    check("in_ready",   bus.in_ready, m_armed && m_st == M_LOAD);
    check("cpu_reset",  cpu_reset,    m_st != M_RUN);
    check("load_done",  load_done,    m_st == M_RUN);
    check("load_err",   load_err,     m_st == M_ERR);
    check("word_count", word_count,   m_wc);
    check("im_we",      bus.im_we,    exp_we);
    if (bus.im_we === 1'b1) begin
      log_addr.push_back(bus.im_addr);
      log_data.push_back(bus.im_wdata);
      if (exp_we) begin
        check("im_addr",  bus.im_addr,  exp_addr.pop_front());
        check("im_wdata", bus.im_wdata, exp_data.pop_front());
      end
    end else if (exp_we) begin
      void'(exp_addr.pop_front());
      void'(exp_data.pop_front());
    end
  end

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic send_frame(input int unsigned len, input int unsigned gap, input bit bad_csum);
    logic [7:0]  s;
    logic [15:0] l;
    logic [31:0] w;
    s = '0;
    l = len[15:0];
    send_byte(l[15:8], gap);
    send_byte(l[7:0], gap);
    foreach (wq[i]) begin
      if (m_st != M_LOAD) break;
      w = wq[i];
      for (int unsigned j = 0; j < 4; j++) begin
        s = s + w[31-8*j -: 8];
        send_byte(w[31-8*j -: 8], gap);
      end
    end
    if (CSUM_EN && m_st == M_LOAD) send_byte(bad_csum ? 8'(s + 8'd1) : s, gap);
    bus.in_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    do_reset();

    // Two-word frame, back to back
    wq = '{32'h20080005, 32'h8C090004};
    send_frame(2, 0, 1'b0);
    check("t1_nwrites", log_addr.size(), 2);
    check("t1_a0", log_addr[0], 0);
    check("t1_w0", log_data[0], 32'h20080005);
    check("t1_a1", log_addr[1], 1);
    check("t1_w1", log_data[1], 32'h8C090004);
    check("t1_done", load_done, 1'b1);
    check("t1_cpu_reset", cpu_reset, 1'b0);
    check("t1_wc", word_count, 2);
    check("t1_ready", bus.in_ready, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    check("t1_model_sum", m_sum, 8'hC6);
`endif
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    bus.in_valid = 1'b0;
    tick();

`ifdef IMEM_LOADER_CSUM_EN
    // Same frame, corrupted checksum
    do_reset();
    send_frame(2, 0, 1'b1);
    check("t2_nwrites", log_addr.size(), 2);
    check("t2_err", load_err, 1'b1);
    check("t2_cpu_reset", cpu_reset, 1'b1);
    check("t2_done", load_done, 1'b0);
`endif

    // Length one over the limit
    do_reset();
    wq = {};
    send_frame(257, 0, 1'b0);
    check("t3_err", load_err, 1'b1);
    check("t3_nwrites", log_addr.size(), 0);
    check("t3_cpu_reset", cpu_reset, 1'b1);

    // Three idle cycles between every byte
    do_reset();
    wq = '{32'h20080005, 32'h8C090004};
    send_frame(2, 3, 1'b0);
    check("t4_nwrites", log_addr.size(), 2);
    check("t4_w0", log_data[0], 32'h20080005);
    check("t4_w1", log_data[1], 32'h8C090004);
    check("t4_done", load_done, 1'b1);
    check("t4_wc", word_count, 2);

    // Reset after six data bytes, then a fresh one-word frame
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
    send_byte(8'h05, 0); send_byte(8'h8C, 0); send_byte(8'h09, 0);
    do_reset();
    wq = '{32'h00000000};
    send_frame(1, 0, 1'b0);
    check("t5_nwrites", log_addr.size(), 1);
    check("t5_a0", log_addr[0], 0);
    check("t5_w0", log_data[0], 32'h00000000);
    check("t5_wc", word_count, 1);
    check("t5_done", load_done, 1'b1);

    // Empty image
    do_reset();
    wq = {};
    send_frame(0, 0, 1'b0);
    check("t6_done", load_done, 1'b1);
    check("t6_nwrites", log_addr.size(), 0);
    check("t6_wc", word_count, 0);

    // Largest image
    do_reset();
    wq = {};
    for (int unsigned i = 0; i < 256; i++) wq.push_back((i * 32'h01030507) ^ 32'hA55A0FF0);
    send_frame(256, 0, 1'b0);
    check("t7_nwrites", log_addr.size(), 256);
    check("t7_last_addr", log_addr[255], 8'hFF);
    check("t7_wc", word_count, 256);
    check("t7_done", load_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
